smc_seq: RTL and testbench

Sequential, handshaked counterpart of the combinational SMC calculator. It accepts six MOSFET descriptors serially, one per `in_valid` beat, plus a mode sampled on the first beat. For each device it evaluates drain current or transconductance, keeps the six results sorted, and returns a weighted 10-bit result with a one-cycle `out_valid` pulse. It is the responder end of the PATTERN-driven SMC protocol when the stimulus is streamed instead of presented in parallel.

---
 rtl/smc_pkg.sv | 39 +++
 rtl/smc_dev_eval.sv | 46 ++++
 rtl/smc_seq.sv | 146 ++++++++++++++
 tb/tb_smc_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/smc_pkg.sv
// smc_pkg -- shared constants, FSM state type and the /3 helper for smc_seq.
//
// Build option: SMC_SEQ_ROUND_EN
//   defined   : every /3 rounds to nearest, computed as (x + 1) / 3
//   undefined : floor division (default)
package smc_pkg;

    localparam int VTH     = 1;   // threshold voltage
    localparam int NUM_DEV = 6;   // devices per frame
    localparam int VAL_W   = 7;   // per-device value width (max 84)
    localparam int OUT_W   = 10;  // result width (max 1008)
    localparam int CNT_W   = 3;   // beat counter width
    localparam int NUM_W   = 10;  // width of the pre-division numerator

    // Weights applied to the selected triple a >= b >= c in current mode.
    localparam int WT_A = 3;
    localparam int WT_B = 4;
    localparam int WT_C = 5;

    // Bit positions inside the 2-bit mode word.
    localparam int MODE_CUR   = 0;  // 1: drain current, 0: gm
    localparam int MODE_LARGE = 1;  // 1: larger three, 0: smaller three

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SUM     = 2'd2,
        OUT     = 2'd3
    } state_t;

    function automatic logic [NUM_W-1:0] div3(input logic [NUM_W-1:0] x);
`ifdef SMC_SEQ_ROUND_EN
        return (x + NUM_W'(1)) / NUM_W'(3);
`else
        return x / NUM_W'(3);
`endif
    endfunction

endpackage

// File: rtl/smc_dev_eval.sv
// smc_dev_eval -- combinational evaluation of one MOSFET descriptor.
// Picks cutoff / triode / saturation and returns drain current or gm,
// divided by 3 (floor, or round-to-nearest under SMC_SEQ_ROUND_EN).
//
// Ports:
//   W           in  3  device width
//   V_GS        in  3  gate-source voltage
//   V_DS        in  3  drain-source voltage
//   sel_current in  1  1: drain current, 0: transconductance
//   val         out 7  evaluated value
module smc_dev_eval
    import smc_pkg::*;
(
    input  logic [2:0]       W,
    input  logic [2:0]       V_GS,
    input  logic [2:0]       V_DS,
    input  logic             sel_current,
    output logic [VAL_W-1:0] val
);

    logic [NUM_W-1:0] w_x, vgs_x, vds_x, vov_x, num;
    logic             cutoff, triode;

    always_comb begin
        w_x    = NUM_W'(W);
        vgs_x  = NUM_W'(V_GS);
        vds_x  = NUM_W'(V_DS);
        vov_x  = vgs_x - NUM_W'(VTH);     // only meaningful when not in cutoff
        cutoff = (vgs_x <= NUM_W'(VTH));
        triode = (vov_x > vds_x);

        num = '0;
        if (!cutoff) begin
            if (triode) begin
                // vov > vds here, so 2*vov*vds - vds^2 cannot go negative
                num = sel_current ? w_x * (NUM_W'(2) * vov_x * vds_x - vds_x * vds_x)
                                  : NUM_W'(2) * w_x * vds_x;
            end else begin
                num = sel_current ? w_x * vov_x * vov_x
                                  : NUM_W'(2) * w_x * vov_x;
            end
        end
        val = VAL_W'(div3(num));
    end

endmodule

// File: rtl/smc_seq.sv
// smc_seq -- streamed SMC calculator. Takes six device descriptors, one per
// in_valid beat (mode latched on beat 0), keeps their values in a descending
// insertion-sorted array, then emits a weighted sum of the larger or smaller
// three as a one-cycle out_valid pulse two edges after the last beat.
//
// Build option: SMC_SEQ_ROUND_EN (round-to-nearest /3, see smc_pkg).
//
// Ports:
//   clk       in  1   clock, rising edge
//   rst_n     in  1   asynchronous active-low reset
//   in_valid  in  1   descriptor beat present
//   mode      in  2   bit0 current/gm, bit1 larger/smaller three (beat 0 only)
//   W         in  3   device width
//   V_GS      in  3   gate-source voltage
//   V_DS      in  3   drain-source voltage
//   out_valid out 1   result valid, one cycle per frame
//   out_n     out 10  result, 0 while out_valid is low
module smc_seq
    import smc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       mode,
    input  logic [2:0]       W,
    input  logic [2:0]       V_GS,
    input  logic [2:0]       V_DS,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_n
);

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [1:0]                     mode_q, mode_d;
    logic [NUM_DEV-1:0][VAL_W-1:0]  arr_q, arr_d;
    logic [OUT_W-1:0]               sum_q, sum_d;
    logic                           out_valid_q, out_valid_d;
    logic [OUT_W-1:0]               out_n_q, out_n_d;

    logic             accept, sel_cur, last_beat;
    logic [VAL_W-1:0] dev_val;
    logic [CNT_W-1:0] pos;
    logic [VAL_W-1:0] a, b, c;
    logic [OUT_W-1:0] res;

    assign accept    = in_valid && (state_q == IDLE || state_q == COLLECT);
    assign last_beat = (cnt_q == CNT_W'(NUM_DEV - 1));
    // On beat 0 mode is not latched yet, so use the live input.
    assign sel_cur   = (state_q == IDLE) ? mode[MODE_CUR] : mode_q[MODE_CUR];

    smc_dev_eval u_eval (
        .W           (W),
        .V_GS        (V_GS),
        .V_DS        (V_DS),
        .sel_current (sel_cur),
        .val         (dev_val)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = COLLECT;
            COLLECT: if (in_valid && last_beat) state_d = SUM;
            SUM:     state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs (registered below) ----------------
    always_comb begin
        out_valid_d = (state_q == OUT);
        out_n_d     = (state_q == OUT) ? sum_q : '0;
    end

    // ---------------- Datapath: counter, mode, sorted insert ----------------
    always_comb begin
        cnt_d  = cnt_q;
        mode_d = mode_q;
        arr_d  = arr_q;

        // Insert position = number of filled entries >= new value, which
        // places the new value after equal ones (arrival order on ties).
        pos = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (CNT_W'(i) < cnt_q && arr_q[i] >= dev_val) pos = pos + CNT_W'(1);
        end

        if (accept) begin
            if (state_q == IDLE) mode_d = mode;
            cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);

            // Entries past the fill level may hold stale data; they are
            // overwritten by the time all six beats have been inserted.
            arr_d[0] = (pos == '0) ? dev_val : arr_q[0];
            for (int i = 1; i < NUM_DEV; i++) begin
                if (CNT_W'(i) < pos)       arr_d[i] = arr_q[i];
                else if (CNT_W'(i) == pos) arr_d[i] = dev_val;
                else                       arr_d[i] = arr_q[i-1];
            end
        end
    end

    // ---------------- Datapath: weighted sum ----------------
    always_comb begin
        if (mode_q[MODE_LARGE]) begin
            a = arr_q[0]; b = arr_q[1]; c = arr_q[2];
        end else begin
            a = arr_q[3]; b = arr_q[4]; c = arr_q[5];
        end
        if (mode_q[MODE_CUR])
            res = OUT_W'(WT_A) * OUT_W'(a) + OUT_W'(WT_B) * OUT_W'(b) + OUT_W'(WT_C) * OUT_W'(c);
        else
            res = OUT_W'(a) + OUT_W'(b) + OUT_W'(c);
        sum_d = (state_q == SUM) ? res : sum_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            mode_q      <= '0;
            arr_q       <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            out_n_q     <= '0;
        end else begin
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            arr_q       <= arr_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
            out_n_q     <= out_n_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_n     = out_n_q;

endmodule

// File: tb/tb_smc_seq.sv
// tb_smc_seq -- self-checking bench for smc_seq: directed frames with known
// results plus randomized frames scored against a behavioural model.
module tb_smc_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] mode;
    logic [2:0] W, V_GS, V_DS;
    logic       out_valid;
    logic [9:0] out_n;

    int n_cmp = 0;
    int n_bad = 0;

    int fw[6], fg[6], fd[6];

    smc_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .mode      (mode),
        .W         (W),
        .V_GS      (V_GS),
        .V_DS      (V_DS),
        .out_valid (out_valid),
        .out_n     (out_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int div3(input int x);
`ifdef SMC_SEQ_ROUND_EN
        return (x + 1) / 3;
`else
        return x / 3;
`endif
    endfunction

    function automatic int dev_model(input int w, input int vgs, input int vds, input bit cur);
        int vov, x;
        if (vgs <= 1) return 0;
        vov = vgs - 1;
        if (vov > vds) x = cur ? w * (2 * vov * vds - vds * vds) : 2 * w * vds;
        else           x = cur ? w * vov * vov : 2 * w * vov;
        return div3(x);
    endfunction

    // Sort the six values high-to-low, pick the requested triple, weight it.
    function automatic int frame_model(input int m);
        int v[6];
        int t, a, b, c;
        for (int i = 0; i < 6; i++) v[i] = dev_model(fw[i], fg[i], fd[i], m[0]);
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 5 - i; j++)
                if (v[j] < v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
        if (m[1]) begin a = v[0]; b = v[1]; c = v[2]; end
        else      begin a = v[3]; b = v[4]; c = v[5]; end
        return m[0] ? 3 * a + 4 * b + 5 * c : a + b + c;
    endfunction

    task automatic idle_garbage();
        in_valid = 1'b0;
        W = 3'($urandom); V_GS = 3'($urandom); V_DS = 3'($urandom); mode = 2'($urandom);
    endtask

    // Stream one frame from fw/fg/fd and check the timing of the result.
    // gap_at/gap_len: idle cycles inserted before beat gap_at.
    // rgap: random idle cycles before each beat. ghost: in_valid held high
    // during SUM and OUT, which must be ignored.
    task automatic send_frame(input string tag, input int m, input int exp,
                              input int gap_at, input int gap_len,
                              input bit rgap, input bit ghost);
        int ng;
        for (int k = 0; k < 6; k++) begin
            ng = (k == gap_at) ? gap_len : 0;
            if (rgap && k > 0) ng = $urandom_range(0, 2);
            repeat (ng) begin
                @(negedge clk);
                idle_garbage();
                chk({tag, "_gap_ov"}, out_valid, 0);
            end
            @(negedge clk);
            chk({tag, "_beat_ov"}, out_valid, 0);
            in_valid = 1'b1;
            W = 3'(fw[k]); V_GS = 3'(fg[k]); V_DS = 3'(fd[k]);
            mode = (k == 0) ? 2'(m) : 2'($urandom);
        end
        @(negedge clk);                       // SUM cycle
        idle_garbage(); in_valid = ghost;
        chk({tag, "_sum_ov"}, out_valid, 0);
        chk({tag, "_sum_n"}, out_n, 0);
        @(negedge clk);                       // OUT cycle
        idle_garbage(); in_valid = ghost;
        chk({tag, "_out_ov"}, out_valid, 0);
        @(negedge clk);                       // result cycle
        idle_garbage();
        chk({tag, "_ov"}, out_valid, 1);
        chk({tag, "_n"}, out_n, exp);
        @(negedge clk);
        chk({tag, "_ov_fall"}, out_valid, 0);
        chk({tag, "_n_zero"}, out_n, 0);
    endtask

    task automatic fill(input int w, input int g, input int d);
        for (int i = 0; i < 6; i++) begin fw[i] = w; fg[i] = g; fd[i] = d; end
    endtask

    initial begin
        int perm[6];
        int seen, m, e;
        perm = '{3, 0, 5, 1, 4, 2};

        rst_n = 1'b0;
        in_valid = 1'b0; mode = '0; W = '0; V_GS = '0; V_DS = '0;
        repeat (2) @(negedge clk);
        chk("rst_ov", out_valid, 0);
        chk("rst_n", out_n, 0);
        rst_n = 1'b1;

        fill(7, 7, 7);
        send_frame("max", 3, 1008, -1, 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            fw[i] = 3; fg[i] = perm[i] + 2; fd[i] = 7;
        end
        send_frame("sat_gm_small", 0, 12, -1, 0, 0, 0);
        send_frame("sat_cur_large", 3, 288, -1, 0, 0, 1);
        send_frame("sat_cur_small", 1, 48, -1, 0, 0, 0);

        fill(3, 7, 2);
        send_frame("tri_cur_large", 3, 240, -1, 0, 0, 0);
        send_frame("tri_gm_large", 2, 12, -1, 0, 0, 0);

        fill(2, 3, 7);
`ifdef SMC_SEQ_ROUND_EN
        send_frame("div3", 3, 36, -1, 0, 0, 0);
`else
        send_frame("div3", 3, 24, -1, 0, 0, 0);
`endif

        fill(5, 1, 6);
        send_frame("cutoff_gap", 3, 0, 3, 3, 0, 0);

        // Reset in the middle of a frame after beat 3.
        fill(7, 7, 7);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1; W = 3'(fw[k]); V_GS = 3'(fg[k]); V_DS = 3'(fd[k]); mode = 2'b11;
        end
        @(negedge clk);
        idle_garbage();
        #2 rst_n = 1'b0;
        #1 chk("midrst_ov", out_valid, 0);
        chk("midrst_n", out_n, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_nopulse", seen, 0);
        send_frame("after_rst", 3, 1008, -1, 0, 0, 0);

        // Randomized frames against the model.
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < 6; i++) begin
                fw[i] = $urandom_range(0, 7);
                fg[i] = $urandom_range(0, 7);
                fd[i] = $urandom_range(0, 7);
            end
            m = $urandom_range(0, 3);
            e = frame_model(m);
            send_frame($sformatf("rnd%0d", f), m, e, -1, 0, 1, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
